// File: rtl/sr_pulse_driver.sv
// Drives an SR latch through active-low S_n/R_n pulses and verifies the result
// against the synchronized Q/Qn feedback. A mismatch triggers a limited number of retries.
`timescale 1ns/1ps
module sr_pulse_driver #(
    parameter int unsigned PULSE_W   = 4,
    parameter int unsigned SETTLE_W  = 3,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_val,
    output logic       req_ready,
    input  logic       Q_fb,
    input  logic       Qn_fb,
    output logic       S_n,
    output logic       R_n,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] dbg_state
);

    // Handshake: a request transfers on a rising clk edge where req_valid and
    // req_ready are both 1; req_val is sampled on that edge only.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PULSE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_t;

    localparam logic [7:0] PULSE_LD  = 8'(PULSE_W - 1);
    localparam logic [7:0] SETTLE_LD = 8'(SETTLE_W - 1);
    localparam logic [3:0] MAX_R     = 4'(MAX_RETRY);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] retry_q, retry_d;
    logic       tgt_q, tgt_d;
    logic       q_meta_q, qs_q, qn_meta_q, qns_q;
    logic       s_n_q, s_n_d, r_n_q, r_n_d;
    logic       busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic       req_ready_q, req_ready_d;
    logic       tgt_match;

    // Feedback synchronizers reset to 1,1 so a fresh reset never looks like a match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_meta_q  <= 1'b1;
            qs_q      <= 1'b1;
            qn_meta_q <= 1'b1;
            qns_q     <= 1'b1;
        end else begin
            q_meta_q  <= Q_fb;
            qs_q      <= q_meta_q;
            qn_meta_q <= Qn_fb;
            qns_q     <= qn_meta_q;
        end
    end

    assign tgt_match = (qs_q == tgt_q) && (qns_q == ~tgt_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        tgt_d   = tgt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    tgt_d   = req_val;
                    retry_d = 4'd0;
                    if ((qs_q == req_val) && (qns_q == ~req_val)) begin
                        state_d = CHECK;
                        done_d  = 1'b1;
                    end else begin
                        state_d = PULSE;
                        cnt_d   = PULSE_LD;
                    end
                end
            end
            PULSE: begin
                if (cnt_q == 8'd0) begin
                    state_d = SETTLE;
                    cnt_d   = SETTLE_LD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            SETTLE: begin
                // The verdict is resolved here so done/err are registered as CHECK begins.
                if (cnt_q == 8'd0) begin
                    state_d = CHECK;
                    if (tgt_match) begin
                        done_d = 1'b1;
                    end else if (retry_q == MAX_R) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            CHECK: begin
                if (done_q) begin
                    state_d = IDLE;
                end else begin
                    retry_d = retry_q + 4'd1;
                    state_d = PULSE;
                    cnt_d   = PULSE_LD;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        s_n_d       = !((state_d == PULSE) && tgt_d);
        r_n_d       = !((state_d == PULSE) && !tgt_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            retry_q     <= 4'd0;
            tgt_q       <= 1'b0;
            s_n_q       <= 1'b1;
            r_n_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            tgt_q       <= tgt_d;
            s_n_q       <= s_n_d;
            r_n_q       <= r_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign S_n       = s_n_q;
    assign R_n       = r_n_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign req_ready = req_ready_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Bench for sr_pulse_driver: NAND-style latch model, randomized requests and a
// scoreboard of expected latency, pulse count, error flag and final latch state.
`timescale 1ns/1ps
module tb_sr_pulse_driver;

    localparam int P       = 4;
    localparam int S       = 3;
    localparam int MR      = 2;
    localparam int ATTEMPT = P + S + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_val = 1'b0;
    logic       req_ready, S_n, R_n, busy, done, err;
    logic [1:0] dbg_state;
    logic       Q_fb, Qn_fb;

    logic latch_q = 1'b0;
    logic stuck_en = 1'b0;
    logic stuck_val = 1'b0;

    int unsigned cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int n_acc = 0;
    int pulse_cnt = 0;

    typedef struct packed {
        logic        check_q;
        logic        tgt;
        logic        err;
        logic [15:0] lat;
        logic [15:0] pulses;
        logic [31:0] acc;
    } exp_t;
    exp_t exp_q[$];

    sr_pulse_driver #(.PULSE_W(P), .SETTLE_W(S), .MAX_RETRY(MR)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_val(req_val),
        .req_ready(req_ready), .Q_fb(Q_fb), .Qn_fb(Qn_fb), .S_n(S_n), .R_n(R_n),
        .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SR latch: a low S_n sets, a low R_n resets.
    always @(S_n or R_n) begin
        if (S_n === 1'b0) latch_q = 1'b1;
        else if (R_n === 1'b0) latch_q = 1'b0;
    end
    assign Q_fb  = stuck_en ? stuck_val : latch_q;
    assign Qn_fb = stuck_en ? !stuck_val : !latch_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outcome from the feedback seen at acceptance and the stuck mode.
    function automatic exp_t model(input logic tgt, input logic fb, input logic stuck);
        exp_t e;
        int attempts;
        e = '0;
        e.tgt = tgt;
        e.check_q = !stuck;
        if (fb == tgt) begin
            e.lat = 16'd1;
        end else begin
            attempts = stuck ? (MR + 1) : 1;
            e.lat    = 16'(attempts * ATTEMPT);
            e.pulses = 16'(attempts * P);
            e.err    = stuck;
        end
        return e;
    endfunction

    always @(posedge rst) begin
        exp_q.delete();
        pulse_cnt = 0;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("sr_both_low", {31'd0, (!S_n && !R_n)}, 32'd0);
            chk("ready_while_busy", {31'd0, (req_ready && busy)}, 32'd0);
            chk("err_without_done", {31'd0, (err && !done)}, 32'd0);
            if (!S_n || !R_n) begin
                pulse_cnt++;
                if (exp_q.size() == 0) chk("pulse_when_idle", 32'd1, 32'd0);
                else chk("pulse_direction", {31'd0, !S_n}, {31'd0, exp_q[0].tgt});
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("latency", cyc - e.acc, {16'd0, e.lat});
                    chk("err_flag", {31'd0, err}, {31'd0, e.err});
                    chk("pulse_cycles", pulse_cnt, {16'd0, e.pulses});
                    if (e.check_q) chk("latch_q", {31'd0, latch_q}, {31'd0, e.tgt});
                end
            end
            if (req_valid && req_ready) begin
                e = model(req_val, Q_fb, stuck_en);
                e.acc = cyc;
                exp_q.push_back(e);
                pulse_cnt = 0;
                n_acc++;
            end
        end
    end

    task automatic settle();
        repeat (3) @(posedge clk);
    endtask

    task automatic do_req(input logic val);
        logic ok;
        ok = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b1;
        req_val = val;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("req_accept_timeout", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_timeout", {31'd0, ok}, 32'd1);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("rst_S_n", {31'd0, S_n}, 32'd1);
        chk("rst_R_n", {31'd0, R_n}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 chk("ready_after_reset", {31'd0, req_ready}, 32'd1);
        settle();

        // Already-matching target, set from 0, repeat set, clear.
        do_req(1'b0); wait_idle();
        do_req(1'b1); wait_idle();
        do_req(1'b1); wait_idle();
        do_req(1'b0); wait_idle();

        // Feedback stuck at Q=0: full retry sequence ending in err.
        stuck_en = 1'b1; stuck_val = 1'b0; settle();
        do_req(1'b1); wait_idle();
        stuck_en = 1'b0; settle();
        do_req(1'b0); wait_idle();

        // Asynchronous reset in the second pulse cycle.
        @(posedge clk);
        #1 req_valid = 1'b1; req_val = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2 chk("S_n_low_before_rst", {31'd0, S_n}, 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("abort_S_n", {31'd0, S_n}, 32'd1);
        chk("abort_R_n", {31'd0, R_n}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_ready", {31'd0, req_ready}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 chk("ready_after_abort", {31'd0, req_ready}, 32'd1);
        settle();

        // Randomized requests, occasionally with stuck feedback.
        for (int n = 0; n < 30; n++) begin
            stuck_en  = ($urandom_range(0, 4) == 0);
            stuck_val = 1'($urandom_range(0, 1));
            settle();
            do_req(1'($urandom_range(0, 1)));
            wait_idle();
            stuck_en = 1'b0;
            settle();
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        // req_valid held high with req_val toggling every cycle.
        begin
            int start_acc;
            logic ok;
            start_acc = n_acc;
            ok = 1'b0;
            @(posedge clk);
            #1 req_valid = 1'b1;
            req_val = 1'($urandom_range(0, 1));
            for (int i = 0; i < 500; i++) begin
                @(posedge clk);
                #1 req_val = !req_val;
                if (n_acc - start_acc >= 10) begin
                    ok = 1'b1;
                    break;
                end
            end
            req_valid = 1'b0;
            chk("toggle_accept_timeout", {31'd0, ok}, 32'd1);
        end
        wait_idle();
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sr_pulse_driver.md
SR_PULSE_DRIVER -- requirements
Module: sr_pulse_driver

Interface
REQ-001 Parameter PULSE_W, default 4: active-low pulse width in clk cycles, legal range 1..255.
REQ-002 Parameter SETTLE_W, default 3: both-inactive settle time in clk cycles, legal range 2..255, so that it covers the feedback synchronizer.
REQ-003 Parameter MAX_RETRY, default 2: extra pulse attempts after the first mismatch, legal range 0..15.
REQ-004 The design SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 req_valid  input  1  request present.
REQ-008 req_val  input  1  target latch state: 1 = set (Q=1), 0 = reset (Q=0).
REQ-009 req_ready  output  1  request accepted on a clk edge where req_valid=1 and req_ready=1.
REQ-010 Q_fb, Qn_fb  input  1 each  asynchronous latch outputs Q and Qn.
REQ-011 S_n, R_n  output  1 each  active-low set and reset drives to the latch; both are idle high.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 err  output  1  one-cycle failure flag; it is only ever high together with done.

Function
REQ-015 Q_fb and Qn_fb SHALL each pass through a 2-flop synchronizer before use; the synchronized values are qs and qns.
REQ-016 FSM states SHALL be IDLE, PULSE, SETTLE and CHECK; all outputs SHALL be registered.
REQ-017 req_ready SHALL equal (state==IDLE); req_val SHALL be captured into tgt at acceptance and later changes of req_val ignored.
REQ-018 At acceptance, if qs==req_val and qns==~req_val, the FSM SHALL go directly to CHECK, with no pulse issued.
REQ-019 At acceptance, if that match does not hold, the FSM SHALL go to PULSE.
REQ-020 Timing is counted in cycles after the acceptance edge t0: PULSE occupies cycles 1..PULSE_W.
REQ-021 During PULSE, S_n=0 if tgt=1, otherwise R_n=0.
REQ-022 SETTLE occupies the next SETTLE_W cycles, with S_n=R_n=1.
REQ-023 CHECK occupies the single cycle that follows SETTLE.
REQ-024 In CHECK, if qs==tgt and qns==~tgt, the block SHALL assert done=1 and err=0 and go to IDLE.
REQ-025 In CHECK, on a mismatch with retry count < MAX_RETRY, the block SHALL increment the retry count, re-enter PULSE next cycle, and not assert done.
REQ-026 In CHECK, on a mismatch with retry count == MAX_RETRY, the block SHALL assert done=1 and err=1 and go to IDLE.
REQ-027 The retry counter SHALL clear on every acceptance.
REQ-028 S_n and R_n SHALL never be low in the same cycle; any state other than PULSE drives both high.
REQ-029 The duration counter SHALL be wide enough for 255 and reload on every PULSE and SETTLE entry; it never wraps.
REQ-030 A new request SHALL be accepted no earlier than the cycle after done (back-to-back throughput = done, then IDLE for 1 cycle).
REQ-031 The FSM SHALL never enter an undefined state; unreachable encodings recover to IDLE.

Reset
REQ-032 While rst=1, outputs SHALL be forced immediately, without waiting for clk: S_n=1, R_n=1, busy=0, done=0, err=0, req_ready=0.
REQ-033 While rst=1, state SHALL be IDLE and counters 0; synchronizer flops SHALL reset to 1,1, which is treated as a mismatch for any target.
REQ-034 After rst deasserts, req_ready SHALL be 1 from the first clk edge.
REQ-035 Reset mid-pulse SHALL abort the operation with no done pulse.

Verification
REQ-036 Set from Q=0 (defaults, behavioural NAND latch model on S_n/R_n): S_n low cycles 1-4 -> done=1, err=0 in cycle 8; R_n stays high throughout.
REQ-037 Request val=0 while the latch already holds Q=0 (synced) -> done=1 in cycle 1; S_n and R_n never go low.
REQ-038 Feedback stuck at Q_fb=0, Qn_fb=1, request val=1 -> exactly 3 S_n pulses of 4 cycles each -> done=1, err=1 in cycle 24.
REQ-039 rst asserted asynchronously in cycle 2 of a pulse -> S_n returns high before the next clk edge; no done pulse; req_ready=1 on the first edge after release.
REQ-040 req_valid held high with req_val toggling each cycle for 10 requests -> no cycle with S_n=R_n=0; req_ready low while busy; each accepted value matches the resulting latch Q at its done.
